// File: rtl/pmem_line_buffer.sv
// pmem_line_buffer: single-entry write-back line buffer between a 16-bit CPU port and 128-bit line memory
module pmem_line_buffer #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        mem_wmask,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic [15:0]       mem_wdata,
  output logic              mem_resp,
  output logic [15:0]       mem_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, RESPOND} state_t;
  state_t              state_q, state_d;
  logic                valid_q, valid_d;
  logic                dirty_q, dirty_d;
  logic [ADDR_W-5:0]   tag_q, tag_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [6:0]          off;
  logic [15:0]         word, merged;
  logic                hit;
  logic                unused_addr0;
  assign unused_addr0 = mem_address[0];
  assign off    = {mem_address[3:1], 4'b0};
  assign word   = line_q[off +: 16];
  assign merged = {mem_wmask[1] ? mem_wdata[15:8] : word[15:8], mem_wmask[0] ? mem_wdata[7:0] : word[7:0]};
  assign hit    = valid_q & (tag_q == mem_address[ADDR_W-1:4]);
  // next-state, buffer updates and memory-side strobes
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    line_d       = line_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      IDLE: if (mem_read | mem_write) state_d = hit ? RESPOND : (valid_q & dirty_q) ? WRITEBACK : FETCH;
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q, 4'b0};
        pmem_wdata   = line_q;
        if (pmem_resp) begin
          dirty_d = 1'b0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[ADDR_W-1:4], 4'b0};
        if (pmem_resp) begin
          line_d  = pmem_rdata;
          tag_d   = mem_address[ADDR_W-1:4];
          valid_d = 1'b1;
          dirty_d = 1'b0;
          state_d = RESPOND;
        end
      end
      RESPOND: begin
        mem_resp  = 1'b1;
        mem_rdata = word;
        if (mem_write) begin
          line_d[off +: 16] = merged;
          dirty_d = dirty_q | (mem_wmask != 2'b00);
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and buffer registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      line_q  <= line_d;
    end
  end
endmodule

// File: tb/tb_pmem_line_buffer.sv
// tb_pmem_line_buffer: directed table-driven bench with a line-memory responder model
module tb_pmem_line_buffer;
  logic         clk = 0;
  logic         reset = 1;
  logic         mem_read = 0, mem_write = 0;
  logic [1:0]   mem_wmask = 0;
  logic [15:0]  mem_address = 0, mem_wdata = 0;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp = 0;
  logic [127:0] pmem_rdata = 0;

  pmem_line_buffer dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [logic [15:0]];
  int delay = 0;
  int wait_cnt = 0;
  int checks = 0;
  int errors = 0;

  // line memory: answers a strobe after 'delay' extra cycles
  always @(negedge clk) begin
    if ((pmem_read | pmem_write) && wait_cnt == delay) begin
      pmem_resp = 1;
      if (pmem_write) mem[pmem_address] = pmem_wdata;
      pmem_rdata = (pmem_read && mem.exists(pmem_address)) ? mem[pmem_address] : 128'h0;
      wait_cnt = 0;
    end else begin
      pmem_resp = 0;
      wait_cnt = (pmem_read | pmem_write) ? wait_cnt + 1 : 0;
    end
  end

  typedef struct {
    logic rd; logic wr; logic [15:0] addr; logic [15:0] wdata; logic [1:0] wmask; int dly;
    logic [15:0] exp_rdata; int exp_lat; int exp_rdc; int exp_wrc; logic [15:0] exp_rda; logic [15:0] exp_wra;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one request from posedge+1 and observe it until mem_resp (bounded)
  task automatic run(input vec_t v, input int idx);
    int lat = 0, rdc = 0, wrc = 0;
    logic [15:0] rda = 0, wra = 0, rdata = 0;
    logic both = 0, done = 0;
    delay = v.dly;
    mem_read = v.rd; mem_write = v.wr; mem_address = v.addr; mem_wdata = v.wdata; mem_wmask = v.wmask;
    while (!done && lat < 50) begin
      @(negedge clk);
      lat++;
      if (pmem_read) begin rdc++; rda = pmem_address; end
      if (pmem_write) begin wrc++; wra = pmem_address; end
      if (pmem_read && pmem_write) both = 1;
      if (mem_resp) begin done = 1; rdata = mem_rdata; end
    end
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0;
    chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d read_cycles", idx), rdc, v.exp_rdc);
    chk($sformatf("v%0d write_cycles", idx), wrc, v.exp_wrc);
    if (v.exp_rdc > 0) chk($sformatf("v%0d read_addr", idx), rda, v.exp_rda);
    if (v.exp_wrc > 0) chk($sformatf("v%0d write_addr", idx), wra, v.exp_wra);
    chk($sformatf("v%0d strobe_overlap", idx), both, 1'b0);
  endtask

  initial begin
    int n;
    mem[16'h0010] = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    mem[16'h0120] = 128'h1207_1206_1205_1204_1203_1202_1201_1200;
    mem[16'h0030] = 128'h3007_3006_3005_3004_3003_3002_3001_3000;
    //            rd wr addr      wdata     mask dly exp_rdata lat rdc wrc rda       wra
    vecs[0]  = '{1, 0, 16'h0016, 16'h0000, 2'b00, 0, 16'h0004, 3, 1, 0, 16'h0010, 16'h0000};
    vecs[1]  = '{1, 0, 16'h0016, 16'h0000, 2'b00, 0, 16'h0004, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[2]  = '{0, 1, 16'h0014, 16'hBEEF, 2'b11, 0, 16'h0003, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[3]  = '{1, 0, 16'h0014, 16'h0000, 2'b00, 0, 16'hBEEF, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[4]  = '{0, 1, 16'h0012, 16'h1234, 2'b11, 0, 16'h0002, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[5]  = '{0, 1, 16'h0013, 16'hAA55, 2'b10, 0, 16'h1234, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[6]  = '{1, 0, 16'h0012, 16'h0000, 2'b00, 0, 16'hAA34, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[7]  = '{0, 1, 16'h0018, 16'hFFFF, 2'b00, 0, 16'h0005, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[8]  = '{1, 0, 16'h0018, 16'h0000, 2'b00, 0, 16'h0005, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[9]  = '{1, 0, 16'h0120, 16'h0000, 2'b00, 0, 16'h1200, 4, 1, 1, 16'h0120, 16'h0010};
    vecs[10] = '{1, 0, 16'h0012, 16'h0000, 2'b00, 3, 16'hAA34, 6, 4, 0, 16'h0010, 16'h0000};
    vecs[11] = '{1, 0, 16'h0014, 16'h0000, 2'b00, 0, 16'hBEEF, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[12] = '{0, 1, 16'h0010, 16'hFFFF, 2'b00, 0, 16'h0001, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[13] = '{1, 0, 16'h0120, 16'h0000, 2'b00, 0, 16'h1200, 3, 1, 0, 16'h0120, 16'h0000};
    vecs[14] = '{1, 1, 16'h0122, 16'h5A5A, 2'b01, 0, 16'h1201, 2, 0, 0, 16'h0000, 16'h0000};
    vecs[15] = '{1, 0, 16'h0122, 16'h0000, 2'b00, 0, 16'h125A, 2, 0, 0, 16'h0000, 16'h0000};
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst mem_resp", mem_resp, 1'b0);
    chk("rst pmem_read", pmem_read, 1'b0);
    chk("rst pmem_write", pmem_write, 1'b0);
    chk("rst pmem_address", pmem_address, 16'h0);
    chk("rst pmem_wdata", pmem_wdata, 128'h0);
    chk("rst mem_rdata", mem_rdata, 16'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) run(vecs[i], i);
    chk("writeback line 0x0010", mem[16'h0010], 128'h0008_0007_0006_0005_0004_BEEF_AA34_0001);
    // reset during FETCH (after the dirty 0x0120 line is written back)
    delay = 0;
    mem_read = 1; mem_address = 16'h0030;
    n = 0;
    do begin @(negedge clk); n++; end while (!pmem_read && n < 20);
    chk("reached fetch", pmem_read, 1'b1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0; mem_read = 0;
    @(negedge clk);
    chk("post-rst pmem_read", pmem_read, 1'b0);
    chk("post-rst pmem_write", pmem_write, 1'b0);
    chk("post-rst mem_resp", mem_resp, 1'b0);
    chk("post-rst pmem_address", pmem_address, 16'h0);
    chk("writeback line 0x0120", mem[16'h0120], 128'h1207_1206_1205_1204_1203_1202_125A_1200);
    @(posedge clk); #1;
    run('{1, 0, 16'h0030, 16'h0000, 2'b00, 0, 16'h3000, 3, 1, 0, 16'h0030, 16'h0000}, 16);
    run('{1, 0, 16'h0122, 16'h0000, 2'b00, 0, 16'h125A, 3, 1, 0, 16'h0120, 16'h0000}, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
